// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit; resets to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_stages;

  // Shift the raw level through the synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) r_stages <= '0;
    else     r_stages <= {r_stages[STAGES-2:0], d};
  end

  assign q = r_stages[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Input debouncer: synchronizes sig_in, then accepts a new level only after it
// has been stable for DEBOUNCE_CYCLES+1 synchronized cycles.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds the 8-bit saturating
// glitch_cnt output counting rejected candidate transitions.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [7:0] glitch_cnt,
`endif
  output logic       sig_out,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_sync;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_sig_out, r_busy;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .q   (w_sync)
  );

  // Next-state and counter logic for the qualification FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_sync) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_sync)               w_state_nxt = IDLE_LOW;
        else if (r_cnt == CNT_MAX) w_state_nxt = IDLE_HIGH;
        else                       w_cnt_nxt   = r_cnt + 1'b1;
      end
      IDLE_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_sync)                w_state_nxt = IDLE_HIGH;
        else if (r_cnt == CNT_MAX) w_state_nxt = IDLE_LOW;
        else                       w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE_LOW;
    endcase
  end

  // State, counter and registered outputs (outputs decoded from next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_sig_out <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sig_out <= (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);
      r_busy    <= (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
    end
  end

  assign sig_out = r_sig_out;
  assign busy    = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       w_abort;
  logic [7:0] r_glitch;

  assign w_abort = ((r_state == WAIT_HIGH) && (w_state_nxt == IDLE_LOW)) ||
                   ((r_state == WAIT_LOW)  && (w_state_nxt == IDLE_HIGH));

  // Saturating count of candidates rejected before qualification
  always_ff @(posedge clk) begin
    if (rst)                             r_glitch <= '0;
    else if (w_abort && r_glitch != '1)  r_glitch <= r_glitch + 8'd1;
  end

  assign glitch_cnt = r_glitch;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: directed scenarios with literal
// expectations plus randomized levels checked every cycle against a
// run-length model of the debouncing rule.
module tb_input_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b1;
  logic sig_out, busy;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .glitch_cnt (glitch_cnt),
`endif
    .sig_out    (sig_out),
    .busy       (busy)
  );

`ifndef DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt = 8'd0;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sync is sig_in delayed SYNC edges; a level flips once
  // the sampled sync value has disagreed with the output for DC+1 edges.
  int m_hist [SYNC];
  int m_out = 0, m_run = 0, m_glitch = 0;

  initial begin
    forever begin
      int s;
      @(posedge clk);
      if (rst) begin
        foreach (m_hist[i]) m_hist[i] = 0;
        m_out = 0; m_run = 0; m_glitch = 0;
      end else begin
        s = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(sig_in);
        if (s != m_out) begin
          m_run++;
          if (m_run == DC + 1) begin
            m_out = 1 - m_out;
            m_run = 0;
          end
        end else begin
          if (m_run > 0 && m_glitch < 255) m_glitch++;
          m_run = 0;
        end
      end
      #1;
      chk("model_sig_out", {7'd0, sig_out}, 8'(m_out));
      chk("model_busy", {7'd0, busy}, 8'(m_run > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("model_glitch", glitch_cnt, 8'(m_glitch));
`endif
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Walk edges 0..18 after a level change, checking the flip at edge 18
  task automatic qualify(input string name, input logic lvl);
    for (int e = 0; e <= 18; e++) begin
      @(posedge clk); #2;
      if (e == 17) chk({name, "_e17"}, {7'd0, sig_out}, {7'd0, ~lvl});
      if (e == 18) chk({name, "_e18"}, {7'd0, sig_out}, {7'd0, lvl});
    end
  endtask

  initial begin
    // Reset held 3 cycles with sig_in high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("rst_sig_out", {7'd0, sig_out}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
    end
    @(negedge clk) rst = 1'b0;
    qualify("post_rst_rise", 1'b1);

    // High to low qualification
    @(negedge clk) sig_in = 1'b0;
    qualify("fall", 1'b0);
    hold(10);

    // Clean rise: busy window edges 2..17
    sig_in = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      @(posedge clk); #2;
      if (e == 1)  chk("rise_busy_e1", {7'd0, busy}, 8'd0);
      if (e == 2)  chk("rise_busy_e2", {7'd0, busy}, 8'd1);
      if (e == 17) chk("rise_busy_e17", {7'd0, busy}, 8'd1);
      if (e == 17) chk("rise_out_e17", {7'd0, sig_out}, 8'd0);
      if (e == 18) chk("rise_out_e18", {7'd0, sig_out}, 8'd1);
      if (e == 18) chk("rise_busy_e18", {7'd0, busy}, 8'd0);
    end
    hold(12);
    sig_in = 1'b0;
    hold(30);

    // Short 5-cycle pulse is rejected
    do_reset();
    sig_in = 1'b1; hold(5);
    sig_in = 1'b0; hold(30);
    chk("pulse5_sig_out", {7'd0, sig_out}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("pulse5_glitch", glitch_cnt, 8'd1);
`endif

    // Four bounces then stable high
    do_reset();
    for (int b = 0; b < 4; b++) begin
      sig_in = 1'b1; hold(3);
      sig_in = 1'b0; hold(3);
    end
    sig_in = 1'b1;
    qualify("bounce_rise", 1'b1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitch", glitch_cnt, 8'd4);
`endif

    // Fall, then reset in the middle of a new rise qualification
    @(negedge clk) sig_in = 1'b0;
    qualify("fall2", 1'b0);
    hold(5);
    sig_in = 1'b1;
    for (int e = 0; e <= 12; e++) @(posedge clk);
    #2 chk("midrise_busy", {7'd0, busy}, 8'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_sig_out", {7'd0, sig_out}, 8'd0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk) rst = 1'b0;
    qualify("requalify", 1'b1);

    // Randomized levels and occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      @(negedge clk);
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        hold($urandom_range(1, 3));
        rst = 1'b0;
      end
      sig_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) hold($urandom_range(15, 20));
      else                           hold($urandom_range(1, 40));
    end
    sig_in = 1'b0;
    hold(30);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Saturation of the glitch counter
    do_reset();
    for (int p = 0; p < 300; p++) begin
      sig_in = 1'b1; hold(3);
      sig_in = 1'b0; hold(3);
    end
    hold(10);
    chk("sat_glitch", glitch_cnt, 8'd255);
    chk("sat_sig_out", {7'd0, sig_out}, 8'd0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on sig_in, legal range 2..4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles needed to accept a level, legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port sig_in, input, 1 bit: raw asynchronous level (button, switch, pin).
REQ-006 SHALL have port sig_out, output, 1 bit: registered debounced level; drives the downstream edge detector's sig_now.
REQ-007 SHALL have port busy, output, 1 bit: high while a candidate transition is being qualified.
REQ-008 SHALL have port glitch_cnt, output, 8 bits, present only under DEBOUNCE_GLITCH_CNT_EN: count of rejected transitions.

Function
REQ-009 SHALL pass sig_in through SYNC_STAGES flops; the last stage is sync_sig; no other logic reads sig_in.
REQ-010 SHALL implement a 4-state FSM: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 SHALL move IDLE_LOW->WAIT_HIGH when sync_sig=1 and clear cnt to 0; otherwise stay in IDLE_LOW.
REQ-012 SHALL, in WAIT_HIGH: if sync_sig=0, return to IDLE_LOW (glitch); else if cnt==DEBOUNCE_CYCLES-1, go to IDLE_HIGH; else increment cnt.
REQ-013 SHALL mirror REQ-011/REQ-012 for IDLE_HIGH/WAIT_LOW with polarity inverted.
REQ-014 SHALL register sig_out=1 in IDLE_HIGH and WAIT_LOW, and sig_out=0 in IDLE_LOW and WAIT_HIGH.
REQ-015 SHALL assert busy only in WAIT_HIGH and WAIT_LOW.
REQ-016 SHALL toggle sig_out at exactly edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new sig_in level as edge 0, when sig_in is held stable (edge 18 with defaults).
REQ-017 SHALL keep sig_out unchanged for any input pulse shorter than DEBOUNCE_CYCLES+1 synchronized cycles.
REQ-018 SHALL restart qualification from cnt=0 after every rejected candidate; no partial credit carries over.
REQ-019 SHALL size cnt as $clog2(DEBOUNCE_CYCLES) bits; cnt never wraps because it stops at DEBOUNCE_CYCLES-1.
REQ-020 SHALL never change sig_out more than once per DEBOUNCE_CYCLES+1 cycles.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, clear all sync flops to 0, set state to IDLE_LOW, cnt to 0, sig_out to 0 and busy to 0.
REQ-022 SHALL let rst take priority over every FSM transition, including mid-WAIT; qualification restarts after release.
REQ-023 SHALL, after reset release with sig_in=1, re-qualify the high level normally per REQ-016, with no shortcut.

Configuration
REQ-024 SHALL use macro DEBOUNCE_GLITCH_CNT_EN.
REQ-025 SHALL, with DEBOUNCE_GLITCH_CNT_EN defined, add port glitch_cnt: increments on each WAIT->IDLE abort, saturates at 255, clears on rst.
REQ-026 SHALL, without DEBOUNCE_GLITCH_CNT_EN, omit the glitch_cnt port and all related logic; the rest of the behaviour is unchanged.

Structure
REQ-027 SHALL place the FSM state enum (2-bit typedef) in shared package debounce_pkg, together with the default SYNC_STAGES and DEBOUNCE_CYCLES constants.
REQ-028 SHALL implement the synchronizer as sub-module sync_ff, parameterized by stage count, reset value 0.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=16, 10 ns clock)
REQ-029 SHALL cover: rst=1 for 3 cycles with sig_in=1 -> sig_out=0 and busy=0 throughout; after release, sig_out=1 at edge 18.
REQ-030 SHALL cover: sig_in 0->1 held 30 cycles -> busy high edges 2..17, sig_out=1 at edge 18, busy=0 at edge 18.
REQ-031 SHALL cover: sig_in high for 5 cycles then low -> sig_out stays 0, glitch_cnt=1.
REQ-032 SHALL cover: four 3-cycle high bounces separated by 3-cycle lows, then stable high -> sig_out rises 18 edges after the stable level starts; glitch_cnt=4.
REQ-033 SHALL cover: from IDLE_HIGH, sig_in 1->0 held -> sig_out=0 at edge 18; then rst pulsed at cnt=10 of a new rise -> sig_out=0, busy=0 the next cycle.
REQ-034 SHALL cover, with DEBOUNCE_GLITCH_CNT_EN: 300 rejected 3-cycle pulses -> glitch_cnt=255 (saturated) and sig_out unchanged.
